// File: rtl/stream_demux_1_n_pkg.sv
// stream_demux_1_n_pkg: shared mode encodings and width helper for the stream demux
package stream_demux_1_n_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Ceiling log2, used to derive SEL_BITS from CHAN_NUM at instantiation
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/stream_demux_1_n_chan_hold_reg.sv
// chan_hold_reg: one-entry output holding register with valid flag
module chan_hold_reg #(
    parameter int BITS_NUM = 2
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [BITS_NUM-1:0] data_i,
    input  logic                load_i,
    input  logic                drain_i,
    output logic [BITS_NUM-1:0] data_o,
    output logic                valid_o
);

    logic [BITS_NUM-1:0] data_q, data_d;
    logic                valid_q, valid_d;

    // Load wins over drain so a full slot can be refilled in the drain cycle; data is kept after drain
    always_comb begin
        data_d  = load_i ? data_i : data_q;
        valid_d = load_i ? 1'b1 : (valid_q && drain_i) ? 1'b0 : valid_q;
    end

    // State register, cleared immediately by reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/stream_demux_1_n.sv
// stream_demux_1_n: registered 1-to-N stream demux routed by select or round-robin pointer
module stream_demux_1_n
    import stream_demux_1_n_pkg::*;
#(
    parameter int BITS_NUM = 2,
    parameter int CHAN_NUM = 4,
    parameter int SEL_BITS = 2
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [BITS_NUM-1:0]          X,
    input  logic                         X_VALID,
    output logic                         X_READY,
    input  logic [SEL_BITS-1:0]          SEL,
    input  logic                         MODE,
    output logic [CHAN_NUM*BITS_NUM-1:0] Y,
    output logic [CHAN_NUM-1:0]          Y_VALID,
    input  logic [CHAN_NUM-1:0]          Y_READY,
    output logic [SEL_BITS-1:0]          RR_PTR,
    output logic                         ERR
);

    logic [SEL_BITS-1:0] tgt, rr_ptr_q, rr_ptr_d;
    logic                legal, tgt_ready, accept, err_q, err_d;
    logic [CHAN_NUM-1:0] load;

    // Target selection, legality, readiness of the target slot and one-hot load decode
    always_comb begin
        tgt       = (MODE == MODE_RR) ? rr_ptr_q : SEL;
        legal     = 1'b0;
        tgt_ready = 1'b0;
        for (int i = 0; i < CHAN_NUM; i++) begin
            if (tgt == SEL_BITS'(i)) begin
                legal     = 1'b1;
                tgt_ready = !Y_VALID[i] || Y_READY[i];
            end
        end
        accept = X_VALID && tgt_ready;
        for (int i = 0; i < CHAN_NUM; i++) begin
            load[i] = accept && (tgt == SEL_BITS'(i));
        end
    end

    assign X_READY = tgt_ready;

    // Pointer advances only on an accepted RR transfer; illegal select with valid data latches the error
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (MODE == MODE_RR && accept) begin
            rr_ptr_d = (rr_ptr_q == SEL_BITS'(CHAN_NUM - 1)) ? '0 : rr_ptr_q + SEL_BITS'(1);
        end
        err_d = err_q || (MODE == MODE_SEL && !legal && X_VALID);
    end

    // Pointer and sticky error registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

    assign RR_PTR = rr_ptr_q;
    assign ERR    = err_q;

    for (genvar c = 0; c < CHAN_NUM; c++) begin : g_chan
        chan_hold_reg #(
            .BITS_NUM(BITS_NUM)
        ) u_hold (
            .CLK    (CLK),
            .RST_N  (RST_N),
            .data_i (X),
            .load_i (load[c]),
            .drain_i(Y_READY[c]),
            .data_o (Y[c*BITS_NUM +: BITS_NUM]),
            .valid_o(Y_VALID[c])
        );
    end

endmodule

// File: tb/tb_stream_demux_1_n.sv
// tb_stream_demux_1_n: directed self-checking bench for the 1-to-N stream demux
module tb_stream_demux_1_n;

    logic       CLK;
    logic       RST_N;
    logic [1:0] X;
    logic       X_VALID;
    logic       X_READY;
    logic [1:0] SEL;
    logic       MODE;
    logic [7:0] Y;
    logic [3:0] Y_VALID;
    logic [3:0] Y_READY;
    logic [1:0] RR_PTR;
    logic       ERR;

    logic [1:0] t3_x;
    logic       t3_x_valid;
    logic       t3_x_ready;
    logic [1:0] t3_sel;
    logic       t3_mode;
    logic [5:0] t3_y;
    logic [2:0] t3_y_valid;
    logic [2:0] t3_y_ready;
    logic [1:0] t3_rr_ptr;
    logic       t3_err;

    int errors = 0;
    int checks = 0;

    stream_demux_1_n #(.BITS_NUM(2), .CHAN_NUM(4), .SEL_BITS(2)) dut (
        .CLK(CLK), .RST_N(RST_N), .X(X), .X_VALID(X_VALID), .X_READY(X_READY),
        .SEL(SEL), .MODE(MODE), .Y(Y), .Y_VALID(Y_VALID), .Y_READY(Y_READY),
        .RR_PTR(RR_PTR), .ERR(ERR)
    );

    stream_demux_1_n #(.BITS_NUM(2), .CHAN_NUM(3), .SEL_BITS(2)) dut3 (
        .CLK(CLK), .RST_N(RST_N), .X(t3_x), .X_VALID(t3_x_valid), .X_READY(t3_x_ready),
        .SEL(t3_sel), .MODE(t3_mode), .Y(t3_y), .Y_VALID(t3_y_valid), .Y_READY(t3_y_ready),
        .RR_PTR(t3_rr_ptr), .ERR(t3_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (Y !== 8'h00) begin errors++; $display("FAIL reset_y: got %h want 00", Y); end
        checks++; if (Y_VALID !== 4'h0) begin errors++; $display("FAIL reset_yvalid: got %b want 0000", Y_VALID); end
        checks++; if (RR_PTR !== 2'd0) begin errors++; $display("FAIL reset_rrptr: got %0d want 0", RR_PTR); end
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", ERR); end
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        checks++; if (X_READY !== 1'b1) begin errors++; $display("FAIL reset_xready: got %b want 1", X_READY); end
    endtask

    task automatic test_sel_mode();
        logic [3:0] ev;
        Y_READY = 4'hf;
        X       = 2'd2;
        X_VALID = 1'b1;
        for (int s = 0; s < 4; s++) begin
            SEL = 2'(s);
            #1;
            checks++; if (X_READY !== 1'b1) begin errors++; $display("FAIL sel_xready[%0d]: got %b want 1", s, X_READY); end
            tick();
            ev = 4'b0001 << s;
            checks++; if (Y_VALID !== ev) begin errors++; $display("FAIL sel_yvalid[%0d]: got %b want %b", s, Y_VALID, ev); end
            checks++; if (Y[s*2 +: 2] !== 2'd2) begin errors++; $display("FAIL sel_y[%0d]: got %0d want 2", s, Y[s*2 +: 2]); end
        end
        X_VALID = 1'b0;
        tick();
        checks++; if (Y_VALID !== 4'h0) begin errors++; $display("FAIL sel_drained: got %b want 0000", Y_VALID); end
        checks++; if (Y !== 8'haa) begin errors++; $display("FAIL sel_y_held: got %h want aa", Y); end
    endtask

    task automatic test_backpressure();
        Y_READY = 4'b1101;
        SEL     = 2'd1;
        X       = 2'd1;
        X_VALID = 1'b1;
        #1;
        checks++; if (X_READY !== 1'b1) begin errors++; $display("FAIL bp_first_ready: got %b want 1", X_READY); end
        tick();
        checks++; if (Y_VALID !== 4'b0010 || Y[3:2] !== 2'd1) begin errors++; $display("FAIL bp_first_load: got v=%b y1=%0d want v=0010 y1=1", Y_VALID, Y[3:2]); end
        X = 2'd3;
        #1;
        checks++; if (X_READY !== 1'b0) begin errors++; $display("FAIL bp_stall_ready: got %b want 0", X_READY); end
        tick();
        checks++; if (Y_VALID !== 4'b0010 || Y[3:2] !== 2'd1) begin errors++; $display("FAIL bp_hold: got v=%b y1=%0d want v=0010 y1=1", Y_VALID, Y[3:2]); end
        Y_READY = 4'hf;
        #1;
        checks++; if (X_READY !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", X_READY); end
        tick();
        checks++; if (Y_VALID !== 4'b0010 || Y[3:2] !== 2'd3) begin errors++; $display("FAIL bp_reload: got v=%b y1=%0d want v=0010 y1=3", Y_VALID, Y[3:2]); end
        X_VALID = 1'b0;
        tick();
        checks++; if (Y_VALID !== 4'h0) begin errors++; $display("FAIL bp_drain: got %b want 0000", Y_VALID); end
    endtask

    task automatic test_round_robin();
        logic [3:0] ev;
        logic [1:0] ch;
        MODE    = 1'b1;
        Y_READY = 4'hf;
        X_VALID = 1'b1;
        for (int k = 0; k < 6; k++) begin
            ch = 2'(k % 4);
            X  = ch;
            #1;
            checks++; if (RR_PTR !== ch) begin errors++; $display("FAIL rr_ptr[%0d]: got %0d want %0d", k, RR_PTR, ch); end
            tick();
            ev = 4'b0001 << ch;
            checks++; if (Y_VALID !== ev || Y[ch*2 +: 2] !== ch) begin errors++; $display("FAIL rr_out[%0d]: got v=%b y=%0d want v=%b y=%0d", k, Y_VALID, Y[ch*2 +: 2], ev, ch); end
        end
        X_VALID = 1'b0;
        tick();
        checks++; if (RR_PTR !== 2'd2) begin errors++; $display("FAIL rr_end_ptr: got %0d want 2", RR_PTR); end
        checks++; if (Y_VALID !== 4'h0) begin errors++; $display("FAIL rr_drain: got %b want 0000", Y_VALID); end
    endtask

    task automatic test_mode_switch();
        MODE    = 1'b0;
        SEL     = 2'd0;
        X       = 2'd3;
        X_VALID = 1'b1;
        #1;
        checks++; if (X_READY !== 1'b1) begin errors++; $display("FAIL ms_ready: got %b want 1", X_READY); end
        tick();
        checks++; if (Y_VALID !== 4'b0001 || Y[1:0] !== 2'd3) begin errors++; $display("FAIL ms_target: got v=%b y0=%0d want v=0001 y0=3", Y_VALID, Y[1:0]); end
        checks++; if (RR_PTR !== 2'd2) begin errors++; $display("FAIL ms_ptr_kept: got %0d want 2", RR_PTR); end
        X_VALID = 1'b0;
        tick();
    endtask

    task automatic test_illegal_select();
        t3_mode    = 1'b0;
        t3_sel     = 2'd3;
        t3_x       = 2'd1;
        t3_y_ready = 3'b111;
        t3_x_valid = 1'b1;
        #1;
        checks++; if (t3_x_ready !== 1'b0) begin errors++; $display("FAIL ill_ready: got %b want 0", t3_x_ready); end
        checks++; if (t3_err !== 1'b0) begin errors++; $display("FAIL ill_err_before: got %b want 0", t3_err); end
        tick();
        checks++; if (t3_err !== 1'b1) begin errors++; $display("FAIL ill_err_set: got %b want 1", t3_err); end
        checks++; if (t3_y_valid !== 3'b000) begin errors++; $display("FAIL ill_no_write: got %b want 000", t3_y_valid); end
        t3_sel     = 2'd0;
        t3_x_valid = 1'b0;
        tick();
        checks++; if (t3_err !== 1'b1) begin errors++; $display("FAIL ill_err_sticky: got %b want 1", t3_err); end
        t3_mode    = 1'b1;
        t3_x_valid = 1'b1;
        tick();
        tick();
        checks++; if (t3_rr_ptr !== 2'd2) begin errors++; $display("FAIL ill_rr_ptr2: got %0d want 2", t3_rr_ptr); end
        tick();
        checks++; if (t3_rr_ptr !== 2'd0 || t3_y_valid !== 3'b100) begin errors++; $display("FAIL ill_rr_wrap: got ptr=%0d v=%b want ptr=0 v=100", t3_rr_ptr, t3_y_valid); end
        t3_x_valid = 1'b0;
        t3_y_ready = 3'b000;
        t3_x       = 2'd3;
        t3_mode    = 1'b0;
        t3_sel     = 2'd1;
        t3_x_valid = 1'b1;
        tick();
        t3_x_valid = 1'b0;
        checks++; if (t3_y_valid !== 3'b110 || t3_err !== 1'b1) begin errors++; $display("FAIL ill_after: got v=%b err=%b want v=110 err=1", t3_y_valid, t3_err); end
    endtask

    task automatic test_async_reset();
        MODE    = 1'b0;
        SEL     = 2'd2;
        X       = 2'd2;
        Y_READY = 4'b1011;
        X_VALID = 1'b1;
        tick();
        X_VALID = 1'b0;
        tick();
        checks++; if (Y_VALID !== 4'b0100 || Y[5:4] !== 2'd2) begin errors++; $display("FAIL ar_pre: got v=%b y2=%0d want v=0100 y2=2", Y_VALID, Y[5:4]); end
        #3;
        RST_N = 1'b0;
        #1;
        checks++; if (Y_VALID !== 4'h0 || Y !== 8'h00) begin errors++; $display("FAIL ar_data: got v=%b y=%h want v=0000 y=00", Y_VALID, Y); end
        checks++; if (RR_PTR !== 2'd0 || ERR !== 1'b0) begin errors++; $display("FAIL ar_ptr_err: got ptr=%0d err=%b want 0 0", RR_PTR, ERR); end
        checks++; if (t3_err !== 1'b0 || t3_y_valid !== 3'b000 || t3_y !== 6'd0) begin errors++; $display("FAIL ar_dut3: got err=%b v=%b y=%h want 0 000 00", t3_err, t3_y_valid, t3_y); end
        @(negedge CLK);
        RST_N   = 1'b1;
        SEL     = 2'd0;
        Y_READY = 4'hf;
        tick();
        checks++; if (X_READY !== 1'b1 || Y_VALID !== 4'h0) begin errors++; $display("FAIL ar_after: got rdy=%b v=%b want 1 0000", X_READY, Y_VALID); end
    endtask

    initial begin
        RST_N      = 1'b0;
        X          = '0;
        X_VALID    = 1'b0;
        SEL        = '0;
        MODE       = 1'b0;
        Y_READY    = '0;
        t3_x       = '0;
        t3_x_valid = 1'b0;
        t3_sel     = '0;
        t3_mode    = 1'b0;
        t3_y_ready = '0;
        test_reset();
        test_sel_mode();
        test_backpressure();
        test_round_robin();
        test_mode_switch();
        test_illegal_select();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
